// File: rtl/l2_mem_responder_if.sv
// L2 line-request bus between the L2 cache (master) and the memory responder (slave).
interface l2_mem_responder_if;
  logic [31:0]  addr_in;
  logic [255:0] data_in;
  logic         rw_in;
  logic         valid_in;
  logic [3:0]   id_in;
  logic [255:0] data_out;
  logic [3:0]   id_out;
  logic         valid_out;
  logic         stall_out;

  modport master (
    output addr_in, data_in, rw_in, valid_in, id_in,
    input  data_out, id_out, valid_out, stall_out
  );

  modport slave (
    input  addr_in, data_in, rw_in, valid_in, id_in,
    output data_out, id_out, valid_out, stall_out
  );
endinterface

// File: rtl/l2_mem_responder.sv
// Main-memory responder below the L2: queues line requests in order and services each one
// after a fixed latency, committing writes to an internal line store or returning read lines.
module l2_mem_responder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned LINE_BITS = 8
) (
  input logic               clk,
  input logic               reset,
  l2_mem_responder_if.slave bus
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = $clog2(DEPTH + 1);
  localparam int unsigned CntW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned Lines  = 2 ** LINE_BITS;

  typedef struct packed {
    logic [LINE_BITS-1:0] idx;
    logic [255:0]         data;
    logic                 rw;
    logic [3:0]           id;
  } req_t;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  req_t         fifo_q [DEPTH];
  // The store powers up zeroed and is deliberately left out of reset.
  logic [255:0] store_q [Lines] = '{default: '0};

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  req_t              work_q, work_d;
  logic [255:0]      data_out_q, data_out_d;
  logic [3:0]        id_out_q, id_out_d;
  logic              valid_out_q, valid_out_d;

  logic full, push, pop, commit;
  req_t push_req;

  // Only the line index matters; the byte offset and high address bits alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_in[31:LINE_BITS+5], bus.addr_in[4:0]};

  // Full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
  assign full   = (count_q == CountW'(DEPTH));
  assign push   = bus.valid_in & ~full;
  assign pop    = (state_q == StIdle) && (count_q != '0);
  assign commit = (state_q == StBusy) && (cnt_q == '0);

  assign push_req = '{idx:  bus.addr_in[LINE_BITS+4:5],
                      data: bus.data_in,
                      rw:   bus.rw_in,
                      id:   bus.id_in};

  // Queue bookkeeping: pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) begin
      count_d = count_q + CountW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CountW'(1);
    end
  end

  // Service FSM: pop into working registers, count down, then act on the line.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    data_out_d  = data_out_q;
    id_out_d    = id_out_q;
    valid_out_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (pop) begin
          work_d  = fifo_q[rd_ptr_q];
          cnt_d   = CntW'(LATENCY - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          if (!work_q.rw) begin
            data_out_d  = store_q[work_q.idx];
            id_out_d    = work_q.id;
            valid_out_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and response registers; reset abandons queued and in-flight requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      work_q      <= '0;
      data_out_q  <= '0;
      id_out_q    <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      work_q      <= work_d;
      data_out_q  <= data_out_d;
      id_out_q    <= id_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  // Queue storage: contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_req;
  end

  // Line store: a write commits only when its service completes.
  always_ff @(posedge clk) begin
    if (commit && work_q.rw) store_q[work_q.idx] <= work_q.data;
  end

  assign bus.data_out  = data_out_q;
  assign bus.id_out    = id_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.stall_out = full;

endmodule
